// File: rtl/fp_stim_pkg.sv
// Shared types and constants for the FP multiply/divide stimulus generator.
package fp_stim_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CORNER,
        ST_RANDOM,
        ST_DRAIN,
        ST_DONE
    } stim_state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        sel;
    } corner_vec_t;

    localparam logic [31:0] LFSR_POLY  = 32'h8020_0003;
    localparam logic [31:0] FP_POS_INF = 32'h7F80_0000;
    localparam logic [31:0] FP_ZERO    = 32'h0000_0000;
    localparam logic [31:0] FP_ONE     = 32'h3F80_0000;

    localparam corner_vec_t CORNER_TABLE [8] = '{
        '{FP_ONE,       32'h4000_0000, 1'b0},
        '{32'h7F00_0000, 32'h7F00_0000, 1'b0},
        '{32'h4040_0000, FP_ZERO,       1'b1},
        '{FP_ZERO,      FP_ONE,        1'b0},
        '{32'hBF80_0000, FP_ONE,        1'b0},
        '{32'h0080_0000, 32'h0080_0000, 1'b0},
        '{FP_POS_INF,   FP_POS_INF,    1'b1},
        '{32'h40A0_0000, 32'h4000_0000, 1'b1}
    };

endpackage

// File: rtl/fp_lfsr32.sv
// 32-bit Galois LFSR that advances on step_i; a zero seed is replaced by 1.
module fp_lfsr32
    import fp_stim_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h0000_0001
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        step_i,
    output logic [31:0] state_o
);

    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h0000_0001 : SEED;

    logic [31:0] state_q, state_d;

    always_comb begin
        state_d = (state_q >> 1) ^ (state_q[0] ? LFSR_POLY : '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SEED_EFF;
        end else if (step_i) begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/fp_stim_gen.sv
// Operand sequencer for the FP mul/div unit: corner burst then LFSR pairs.
// Define FP_STIM_CORNER_EN to synthesize the corner-case phase and table.
module fp_stim_gen
    import fp_stim_pkg::*;
#(
    parameter int unsigned LATENCY     = 1,
    parameter int unsigned NUM_VECTORS = 256,
    parameter logic [31:0] SEED        = 32'hACE1_2024
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        start,
    input  logic        stall,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic        sel,
    output logic        en,
    output logic        chk_strobe,
    output logic [15:0] vec_idx,
    output logic        busy,
    output logic        done
);

    localparam logic [15:0] LAST_IDX = 16'(NUM_VECTORS - 1);
    localparam logic [3:0]  LAT      = 4'(LATENCY);
`ifdef FP_STIM_CORNER_EN
    localparam stim_state_t FIRST_ST = ST_CORNER;
`else
    localparam stim_state_t FIRST_ST = ST_RANDOM;
`endif

    stim_state_t        state_q, state_d;
    logic [31:0]        a_q, a_d, b_q, b_d;
    logic               sel_q, sel_d, en_q, en_d;
    logic [15:0]        vidx_q, vidx_d, cnt_q, cnt_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic [3:0]         drain_q, drain_d;
    logic [LATENCY-1:0] dl_q, dl_d;
    logic [LATENCY:0]   dl_ext;
    logic               step;
    logic [31:0]        lfsr_a, lfsr_b;
`ifdef FP_STIM_CORNER_EN
    corner_vec_t        corner;
`endif

    fp_lfsr32 #(.SEED(SEED)) u_lfsr_a (
        .clk_i(clk), .rst_ni(arst), .step_i(step), .state_o(lfsr_a)
    );

    fp_lfsr32 #(.SEED(~SEED)) u_lfsr_b (
        .clk_i(clk), .rst_ni(arst), .step_i(step), .state_o(lfsr_b)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        en_d    = 1'b0;
        vidx_d  = vidx_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        drain_d = drain_q;
        step    = 1'b0;
        // strobe delay line runs every cycle, regardless of stall
        dl_ext  = {dl_q, en_q};
        dl_d    = dl_ext[LATENCY-1:0];
`ifdef FP_STIM_CORNER_EN
        corner  = CORNER_TABLE[cnt_q[2:0]];
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = FIRST_ST;
                    busy_d  = 1'b1;
                    vidx_d  = '0;
                    cnt_d   = '0;
                end
            end
`ifdef FP_STIM_CORNER_EN
            ST_CORNER: begin
                if (!stall) begin
                    a_d    = corner.a;
                    b_d    = corner.b;
                    sel_d  = corner.sel;
                    en_d   = 1'b1;
                    vidx_d = cnt_q;
                    cnt_d  = cnt_q + 16'd1;
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_DRAIN;
                        drain_d = '0;
                    end else if (cnt_q[2:0] == 3'd7) begin
                        state_d = ST_RANDOM;
                    end
                end
            end
`endif
            ST_RANDOM: begin
                if (!stall) begin
                    a_d    = lfsr_a;
                    b_d    = lfsr_b;
                    sel_d  = lfsr_a[0] ^ lfsr_b[0];
                    step   = 1'b1;
                    en_d   = 1'b1;
                    vidx_d = cnt_q;
                    cnt_d  = cnt_q + 16'd1;
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_DRAIN;
                        drain_d = '0;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q == LAT) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    drain_d = drain_q + 4'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= 1'b0;
            en_q    <= 1'b0;
            vidx_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            drain_q <= '0;
            dl_q    <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            vidx_q  <= vidx_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            drain_q <= drain_d;
            dl_q    <= dl_d;
        end
    end

    assign a          = a_q;
    assign b          = b_q;
    assign sel        = sel_q;
    assign en         = en_q;
    assign chk_strobe = dl_q[LATENCY-1];
    assign vec_idx    = vidx_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_fp_stim_gen.sv
// Directed bench for fp_stim_gen: three instances with different LATENCY/NUM_VECTORS/SEED.
module tb_fp_stim_gen;

    logic       clk  = 1'b0;
    logic       arst = 1'b0;
    logic [2:0] start_v = '0;
    logic [2:0] stall_v = '0;

    logic [31:0] a_w [3];
    logic [31:0] b_w [3];
    logic        sel_w [3];
    logic        en_w [3];
    logic        chk_w [3];
    logic [15:0] vi_w [3];
    logic        busy_w [3];
    logic        done_w [3];

    int n_vec = 0;
    int n_err = 0;

    bit          start_plan [64];
    bit          stall_plan [64];
    logic        cap_en [64];
    logic        cap_chk [64];
    logic        cap_done [64];
    logic        cap_busy [64];
    logic        cap_sel [64];
    logic [31:0] cap_a [64];
    logic [31:0] cap_b [64];
    logic [15:0] cap_vi [64];

    always #5 clk = ~clk;

    fp_stim_gen #(.LATENCY(1), .NUM_VECTORS(8), .SEED(32'hACE1_2024)) u0 (
        .clk(clk), .arst(arst), .start(start_v[0]), .stall(stall_v[0]),
        .a(a_w[0]), .b(b_w[0]), .sel(sel_w[0]), .en(en_w[0]), .chk_strobe(chk_w[0]),
        .vec_idx(vi_w[0]), .busy(busy_w[0]), .done(done_w[0])
    );

    fp_stim_gen #(.LATENCY(1), .NUM_VECTORS(10), .SEED(32'h0000_0001)) u1 (
        .clk(clk), .arst(arst), .start(start_v[1]), .stall(stall_v[1]),
        .a(a_w[1]), .b(b_w[1]), .sel(sel_w[1]), .en(en_w[1]), .chk_strobe(chk_w[1]),
        .vec_idx(vi_w[1]), .busy(busy_w[1]), .done(done_w[1])
    );

    fp_stim_gen #(.LATENCY(4), .NUM_VECTORS(12), .SEED(32'hACE1_2024)) u2 (
        .clk(clk), .arst(arst), .start(start_v[2]), .stall(stall_v[2]),
        .a(a_w[2]), .b(b_w[2]), .sel(sel_w[2]), .en(en_w[2]), .chk_strobe(chk_w[2]),
        .vec_idx(vi_w[2]), .busy(busy_w[2]), .done(done_w[2])
    );

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic clear_plans();
        for (int i = 0; i < 64; i++) begin
            start_plan[i] = 1'b0;
            stall_plan[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        arst = 1'b0;
        start_v = '0;
        stall_v = '0;
        repeat (2) @(negedge clk);
        arst = 1'b1;
        @(negedge clk);
    endtask

    // Index 0 is sampled just after the edge that accepts start.
    task automatic run_capture(input int d, input int ncyc);
        start_v[d] = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            cap_en[c]   = en_w[d];
            cap_chk[c]  = chk_w[d];
            cap_done[c] = done_w[d];
            cap_busy[c] = busy_w[d];
            cap_sel[c]  = sel_w[d];
            cap_a[c]    = a_w[d];
            cap_b[c]    = b_w[d];
            cap_vi[c]   = vi_w[d];
            start_v[d]  = start_plan[c];
            stall_v[d]  = stall_plan[c];
        end
        start_v = '0;
        stall_v = '0;
    endtask

    task automatic test_reset();
        arst = 1'b0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            if ({a_w[d], b_w[d], sel_w[d], en_w[d], chk_w[d], vi_w[d], busy_w[d], done_w[d]} !== 86'h0) begin
                $display("FAIL reset_outputs u%0d: got a=%h b=%h sel=%b en=%b chk=%b vi=%h busy=%b done=%b, required all 0",
                         d, a_w[d], b_w[d], sel_w[d], en_w[d], chk_w[d], vi_w[d], busy_w[d], done_w[d]);
                n_err++;
            end
            n_vec++;
        end
        arst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_corner_burst();
        logic [31:0] ea [8];
        logic [31:0] eb [8];
        logic        es [8];
        logic [3:0]  got, exp;
        ea = '{32'h3F800000, 32'h7F000000, 32'h40400000, 32'h00000000,
               32'hBF800000, 32'h00800000, 32'h7F800000, 32'h40A00000};
        eb = '{32'h40000000, 32'h7F000000, 32'h00000000, 32'h3F800000,
               32'h3F800000, 32'h00800000, 32'h7F800000, 32'h40000000};
        es = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        clear_plans();
        run_capture(0, 14);
        for (int c = 0; c < 14; c++) begin
            exp = {(c >= 1 && c <= 8), (c >= 2 && c <= 9), (c == 10), (c < 10)};
            got = {cap_en[c], cap_chk[c], cap_done[c], cap_busy[c]};
            if (got !== exp) begin
                $display("FAIL burst_timing cyc%0d: got en/chk/done/busy=%b, required %b", c, got, exp);
                n_err++;
            end
            n_vec++;
        end
        for (int c = 1; c <= 8; c++) begin
            if (cap_vi[c] !== 16'(c - 1)) begin
                $display("FAIL burst_vec_idx cyc%0d: got %0d, required %0d", c, cap_vi[c], c - 1);
                n_err++;
            end
            n_vec++;
        end
`ifdef FP_STIM_CORNER_EN
        for (int c = 1; c <= 8; c++) begin
            if ({cap_a[c], cap_b[c], cap_sel[c]} !== {ea[c-1], eb[c-1], es[c-1]}) begin
                $display("FAIL corner_entry%0d: got %h/%h/%b, required %h/%h/%b",
                         c - 1, cap_a[c], cap_b[c], cap_sel[c], ea[c-1], eb[c-1], es[c-1]);
                n_err++;
            end
            n_vec++;
        end
`else
        if ({cap_a[1], cap_b[1], cap_sel[1]} !== {32'hACE12024, 32'h531EDFDB, 1'b1}) begin
            $display("FAIL random_first: got %h/%h/%b, required ace12024/531edfdb/1 (table entry 0 is %h)",
                     cap_a[1], cap_b[1], cap_sel[1], ea[0]);
            n_err++;
        end
        n_vec++;
        if ({cap_a[2], cap_b[2], cap_sel[2]} !== {32'h56709012, 32'hA9AF6FEE, 1'b0}) begin
            $display("FAIL random_second: got %h/%h/%b, required 56709012/a9af6fee/0",
                     cap_a[2], cap_b[2], cap_sel[2]);
            n_err++;
        end
        n_vec++;
        if ({eb[0], es[0]} === 33'h0) $display("note: unused table"); // keeps table referenced
`endif
    endtask

    task automatic test_seed_tail();
        int          en_cnt;
        int          i0;
        logic [3:0]  got, exp;
        do_reset();
        clear_plans();
        run_capture(1, 16);
        en_cnt = 0;
        for (int c = 0; c < 16; c++) begin
            if (cap_en[c]) en_cnt++;
            exp = {(c >= 1 && c <= 10), (c >= 2 && c <= 11), (c == 12), (c < 12)};
            got = {cap_en[c], cap_chk[c], cap_done[c], cap_busy[c]};
            if (got !== exp) begin
                $display("FAIL seed_timing cyc%0d: got en/chk/done/busy=%b, required %b", c, got, exp);
                n_err++;
            end
            n_vec++;
        end
        if (en_cnt != 10) begin
            $display("FAIL seed_en_count: got %0d, required 10", en_cnt);
            n_err++;
        end
        n_vec++;
`ifdef FP_STIM_CORNER_EN
        i0 = 9;
`else
        i0 = 1;
`endif
        if ({cap_a[i0], cap_b[i0], cap_sel[i0], cap_vi[i0]} !== {32'h00000001, 32'hFFFFFFFE, 1'b1, 16'(i0 - 1)}) begin
            $display("FAIL seed_first_random: got %h/%h/%b idx %0d, required 00000001/fffffffe/1 idx %0d",
                     cap_a[i0], cap_b[i0], cap_sel[i0], cap_vi[i0], i0 - 1);
            n_err++;
        end
        n_vec++;
        if ({cap_a[i0+1], cap_b[i0+1], cap_sel[i0+1]} !== {32'h80200003, 32'h7FFFFFFF, 1'b0}) begin
            $display("FAIL seed_second_random: got %h/%h/%b, required 80200003/7fffffff/0",
                     cap_a[i0+1], cap_b[i0+1], cap_sel[i0+1]);
            n_err++;
        end
        n_vec++;
    endtask

    task automatic test_stall();
        logic [31:0] va, vb;
        logic [3:0]  got, exp;
        bit          en_e;
        bit          chk_e;
`ifdef FP_STIM_CORNER_EN
        va = 32'h40400000;
        vb = 32'h00000000;
`else
        va = 32'hC0300002;
        vb = 32'hBFDFFFFC;
`endif
        do_reset();
        clear_plans();
        for (int c = 3; c <= 5; c++) stall_plan[c] = 1'b1;
        run_capture(1, 20);
        for (int c = 0; c < 20; c++) begin
            en_e  = (c >= 1 && c <= 3) || (c >= 7 && c <= 13);
            chk_e = (c >= 2 && c <= 4) || (c >= 8 && c <= 14);
            exp = {en_e, chk_e, (c == 15), (c < 15)};
            got = {cap_en[c], cap_chk[c], cap_done[c], cap_busy[c]};
            if (got !== exp) begin
                $display("FAIL stall_timing cyc%0d: got en/chk/done/busy=%b, required %b", c, got, exp);
                n_err++;
            end
            n_vec++;
        end
        for (int c = 3; c <= 6; c++) begin
            if ({cap_a[c], cap_b[c], cap_vi[c]} !== {va, vb, 16'd2}) begin
                $display("FAIL stall_hold cyc%0d: got %h/%h idx %0d, required %h/%h idx 2",
                         c, cap_a[c], cap_b[c], cap_vi[c], va, vb);
                n_err++;
            end
            n_vec++;
        end
        if (cap_vi[7] !== 16'd3) begin
            $display("FAIL stall_resume_idx: got %0d, required 3", cap_vi[7]);
            n_err++;
        end
        n_vec++;
    endtask

    task automatic test_latency4();
        logic [3:0] got, exp;
        do_reset();
        clear_plans();
        run_capture(2, 24);
        for (int c = 0; c < 24; c++) begin
            exp = {(c >= 1 && c <= 12), (c >= 5 && c <= 16), (c == 17), (c < 17)};
            got = {cap_en[c], cap_chk[c], cap_done[c], cap_busy[c]};
            if (got !== exp) begin
                $display("FAIL lat4_timing cyc%0d: got en/chk/done/busy=%b, required %b", c, got, exp);
                n_err++;
            end
            n_vec++;
        end
    endtask

    task automatic test_restart_abort();
        logic [3:0] got;
        do_reset();
        clear_plans();
        start_plan[2] = 1'b1;
        run_capture(2, 10);
        for (int c = 1; c <= 9; c++) begin
            if ({cap_en[c], cap_vi[c]} !== {1'b1, 16'(c - 1)}) begin
                $display("FAIL restart_ignored cyc%0d: got en=%b idx %0d, required en=1 idx %0d",
                         c, cap_en[c], cap_vi[c], c - 1);
                n_err++;
            end
            n_vec++;
        end
        #2 arst = 1'b0;
        #1;
        if ({a_w[2], b_w[2], sel_w[2], en_w[2], chk_w[2], vi_w[2], busy_w[2], done_w[2]} !== 86'h0) begin
            $display("FAIL abort_outputs: got a=%h b=%h sel=%b en=%b chk=%b vi=%h busy=%b done=%b, required all 0",
                     a_w[2], b_w[2], sel_w[2], en_w[2], chk_w[2], vi_w[2], busy_w[2], done_w[2]);
            n_err++;
        end
        n_vec++;
        @(negedge clk);
        arst = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            got = {en_w[2], chk_w[2], done_w[2], busy_w[2]};
            if (got !== 4'b0000) begin
                $display("FAIL abort_quiet cyc%0d: got en/chk/done/busy=%b, required 0000", c, got);
                n_err++;
            end
            n_vec++;
        end
    endtask

    initial begin
        test_reset();
        test_corner_burst();
        test_seed_tail();
        test_stall();
        test_latency4();
        test_restart_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
